// File: rtl/c_mem_stage.sv
// c_mem_stage: memory-access stage between the ALU stage and writeback.
// Non-memory records are passed through to writeback one cycle later. Aligned
// loads/stores go out over a req/ack data-memory port, and the writeback record
// is emitted one cycle after the ack. Misaligned accesses and accesses that go
// TIMEOUT request cycles without an ack are reported through cw_mem_err.
//
// Ports:
//   clock, reset               clock, asynchronous active-low reset
//   a_ready, ac_*, ALU_result  ALU-stage record (a_ready qualifies it for one cycle)
//   c_ready                    stage can accept a record at the next edge
//   mem_req/we/addr/wdata      data-memory request, held until ack or abort
//   mem_ack, mem_rdata         data-memory completion and load data
//   cw_*                       registered writeback record (cw_valid is a pulse)
module c_mem_stage #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        a_ready,
  input  logic [31:0] ac_pc,
  input  logic [4:0]  ac_write_sel,
  input  logic        ac_is_load,
  input  logic        ac_is_store,
  input  logic        ac_is_wb,
  input  logic [31:0] ALU_result,
  input  logic [31:0] ac_store_data,
  output logic        c_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        cw_valid,
  output logic [31:0] cw_pc,
  output logic [4:0]  cw_write_sel,
  output logic        cw_is_wb,
  output logic [31:0] cw_data,
  output logic        cw_mem_err
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {IDLE, MEM} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  // Record fields not already held on the memory port; the latched ALU result
  // lives in mem_addr_q and the store/load kind in mem_we_q.
  logic [31:0]       rec_pc_q, rec_pc_d;
  logic [4:0]        rec_write_sel_q, rec_write_sel_d;
  logic              rec_is_wb_q, rec_is_wb_d;

  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              cw_valid_q, cw_valid_d;
  logic [31:0]       cw_pc_q, cw_pc_d;
  logic [4:0]        cw_write_sel_q, cw_write_sel_d;
  logic              cw_is_wb_q, cw_is_wb_d;
  logic [31:0]       cw_data_q, cw_data_d;
  logic              cw_mem_err_q, cw_mem_err_d;

  logic is_mem;
  logic aligned;

  assign is_mem  = ac_is_load | ac_is_store;
  assign aligned = (ALU_result[1:0] == 2'b00);

  // Accepting a memory access this edge means the following cycle is busy, so
  // ready drops combinationally to stop the ALU stage launching behind it.
  assign c_ready = (state_q == IDLE) && !(a_ready && is_mem && aligned);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d         = state_q;
    cnt_d           = cnt_q;
    rec_pc_d        = rec_pc_q;
    rec_write_sel_d = rec_write_sel_q;
    rec_is_wb_d     = rec_is_wb_q;
    mem_req_d       = mem_req_q;
    mem_we_d        = mem_we_q;
    mem_addr_d      = mem_addr_q;
    mem_wdata_d     = mem_wdata_q;
    cw_valid_d      = 1'b0;
    cw_pc_d         = cw_pc_q;
    cw_write_sel_d  = cw_write_sel_q;
    cw_is_wb_d      = cw_is_wb_q;
    cw_data_d       = cw_data_q;
    cw_mem_err_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (a_ready) begin
          if (is_mem && aligned) begin
            state_d         = MEM;
            cnt_d           = '0;
            rec_pc_d        = ac_pc;
            rec_write_sel_d = ac_write_sel;
            rec_is_wb_d     = ac_is_wb;
            mem_req_d       = 1'b1;
            mem_we_d        = ac_is_store;  // load+store together is a store
            mem_addr_d      = ALU_result;
            mem_wdata_d     = ac_store_data;
          end else begin
            cw_valid_d     = 1'b1;
            cw_pc_d        = ac_pc;
            cw_write_sel_d = ac_write_sel;
            cw_data_d      = ALU_result;
            if (is_mem) begin
              // Misaligned access: never reaches the memory port.
              cw_mem_err_d = 1'b1;
              cw_is_wb_d   = 1'b0;
            end else begin
              cw_is_wb_d = ac_is_wb && (ac_write_sel != 5'd0);
            end
          end
        end
      end

      MEM: begin
        if (mem_ack || (cnt_q == CNT_LAST)) begin
          // Ack takes priority over a coincident timeout.
          state_d        = IDLE;
          mem_req_d      = 1'b0;
          cw_valid_d     = 1'b1;
          cw_pc_d        = rec_pc_q;
          cw_write_sel_d = rec_write_sel_q;
          cw_data_d      = (mem_ack && !mem_we_q) ? mem_rdata : mem_addr_q;
          cw_mem_err_d   = !mem_ack;
          cw_is_wb_d     = mem_ack && rec_is_wb_q && (rec_write_sel_q != 5'd0);
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      rec_pc_q        <= '0;
      rec_write_sel_q <= '0;
      rec_is_wb_q     <= 1'b0;
      mem_req_q       <= 1'b0;
      mem_we_q        <= 1'b0;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
      cw_valid_q      <= 1'b0;
      cw_pc_q         <= '0;
      cw_write_sel_q  <= '0;
      cw_is_wb_q      <= 1'b0;
      cw_data_q       <= '0;
      cw_mem_err_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      rec_pc_q        <= rec_pc_d;
      rec_write_sel_q <= rec_write_sel_d;
      rec_is_wb_q     <= rec_is_wb_d;
      mem_req_q       <= mem_req_d;
      mem_we_q        <= mem_we_d;
      mem_addr_q      <= mem_addr_d;
      mem_wdata_q     <= mem_wdata_d;
      cw_valid_q      <= cw_valid_d;
      cw_pc_q         <= cw_pc_d;
      cw_write_sel_q  <= cw_write_sel_d;
      cw_is_wb_q      <= cw_is_wb_d;
      cw_data_q       <= cw_data_d;
      cw_mem_err_q    <= cw_mem_err_d;
    end
  end

  assign mem_req      = mem_req_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign cw_valid     = cw_valid_q;
  assign cw_pc        = cw_pc_q;
  assign cw_write_sel = cw_write_sel_q;
  assign cw_is_wb     = cw_is_wb_q;
  assign cw_data      = cw_data_q;
  assign cw_mem_err   = cw_mem_err_q;

endmodule

// File: tb/tb_c_mem_stage.sv
// Testbench for c_mem_stage (TIMEOUT=4). Each record is driven at the start of
// a cycle; outputs are sampled 1 ns later, well away from the rising edge.
// Expected behaviour comes from a transaction-level model: given the record
// and the cycle in which memory acks, it yields the writeback latency, the
// number of request cycles, the data and the error/writeback flags.
module tb_c_mem_stage;

  localparam int TO = 4;

  logic        clock, reset;
  logic        a_ready;
  logic [31:0] ac_pc;
  logic [4:0]  ac_write_sel;
  logic        ac_is_load, ac_is_store, ac_is_wb;
  logic [31:0] ALU_result, ac_store_data;
  logic        c_ready;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        cw_valid;
  logic [31:0] cw_pc;
  logic [4:0]  cw_write_sel;
  logic        cw_is_wb;
  logic [31:0] cw_data;
  logic        cw_mem_err;

  int checks   = 0;
  int failures = 0;

  c_mem_stage #(.TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .a_ready(a_ready), .ac_pc(ac_pc),
    .ac_write_sel(ac_write_sel), .ac_is_load(ac_is_load), .ac_is_store(ac_is_store),
    .ac_is_wb(ac_is_wb), .ALU_result(ALU_result), .ac_store_data(ac_store_data),
    .c_ready(c_ready), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .cw_valid(cw_valid), .cw_pc(cw_pc), .cw_write_sel(cw_write_sel),
    .cw_is_wb(cw_is_wb), .cw_data(cw_data), .cw_mem_err(cw_mem_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  sel;
    logic        is_load;
    logic        is_store;
    logic        is_wb;
    logic [31:0] result;
    logic [31:0] sdata;
  } op_t;

  typedef struct {
    int          lat;         // cycles from a_ready to cw_valid
    int          req_cycles;  // cycles mem_req is high, starting at N+1
    logic        accepted;    // record went to the memory port
    logic        err;
    logic        wb;
    logic [31:0] data;
  } exp_t;

  function automatic op_t mk_op(logic [31:0] pc, logic [4:0] sel, logic ld, logic st,
                                logic wb, logic [31:0] res, logic [31:0] sd);
    op_t o;
    o.pc = pc; o.sel = sel; o.is_load = ld; o.is_store = st;
    o.is_wb = wb; o.result = res; o.sdata = sd;
    return o;
  endfunction

  // d = cycle offset (from N) at which memory acks; d > TO means it never does.
  function automatic exp_t model(op_t op, int d, logic [31:0] rdata);
    exp_t e;
    logic is_mem, is_aligned;
    is_mem     = op.is_load || op.is_store;
    is_aligned = (op.result % 4) == 0;
    e.accepted = is_mem && is_aligned;
    e.err = 1'b0; e.data = op.result; e.req_cycles = 0; e.lat = 1;
    if (is_mem && !is_aligned) begin
      e.err = 1'b1;
    end else if (e.accepted) begin
      if (d <= TO) begin
        e.req_cycles = d;
        e.lat        = d + 1;
        if (!op.is_store) e.data = rdata;
      end else begin
        e.req_cycles = TO;
        e.lat        = TO + 1;
        e.err        = 1'b1;
      end
    end
    e.wb = op.is_wb && (op.sel != 0) && !e.err;
    return e;
  endfunction

  task automatic idle_inputs();
    a_ready = 1'b0; ac_pc = '0; ac_write_sel = '0; ac_is_load = 1'b0;
    ac_is_store = 1'b0; ac_is_wb = 1'b0; ALU_result = '0; ac_store_data = '0;
    mem_ack = 1'b0; mem_rdata = '0;
  endtask

  // Drives one record in the current cycle N and follows it to its writeback.
  // Returns mid-cycle N+lat so the next record can be presented back-to-back.
  task automatic run_op(input string name, input op_t op, input int d,
                        input logic [31:0] rdata, input logic stray_ack);
    exp_t e;
    e = model(op, d, rdata);
    a_ready = 1'b1; ac_pc = op.pc; ac_write_sel = op.sel; ac_is_load = op.is_load;
    ac_is_store = op.is_store; ac_is_wb = op.is_wb; ALU_result = op.result;
    ac_store_data = op.sdata; mem_ack = stray_ack; mem_rdata = $urandom;
    #1;
    checks++;
    if (c_ready !== !e.accepted) begin
      failures++; $display("FAIL %s c_ready@N got=%b exp=%b", name, c_ready, !e.accepted);
    end
    for (int k = 1; k <= e.lat; k++) begin
      @(posedge clock); #1;
      a_ready = 1'b0; ALU_result = $urandom; ac_store_data = $urandom;
      ac_is_load = 1'(($urandom)); ac_is_store = 1'($urandom);
      mem_ack   = e.accepted && (k == d);
      mem_rdata = (k == d) ? rdata : $urandom;
      #1;
      checks++;
      if (mem_req !== (k <= e.req_cycles)) begin
        failures++; $display("FAIL %s mem_req@N+%0d got=%b exp=%b", name, k, mem_req, k <= e.req_cycles);
      end
      checks++;
      if (c_ready !== (k > e.req_cycles)) begin
        failures++; $display("FAIL %s c_ready@N+%0d got=%b exp=%b", name, k, c_ready, k > e.req_cycles);
      end
      checks++;
      if (cw_valid !== (k == e.lat)) begin
        failures++; $display("FAIL %s cw_valid@N+%0d got=%b exp=%b", name, k, cw_valid, k == e.lat);
      end
      checks++;
      if (cw_mem_err !== (k == e.lat && e.err)) begin
        failures++; $display("FAIL %s cw_mem_err@N+%0d got=%b exp=%b", name, k, cw_mem_err, k == e.lat && e.err);
      end
      if (k <= e.req_cycles) begin
        checks++;
        if (mem_we !== op.is_store || mem_addr !== op.result || mem_wdata !== op.sdata) begin
          failures++;
          $display("FAIL %s mem_port@N+%0d got we=%b addr=%h wdata=%h exp we=%b addr=%h wdata=%h",
                   name, k, mem_we, mem_addr, mem_wdata, op.is_store, op.result, op.sdata);
        end
      end
      if (k == e.lat) begin
        checks++;
        if (cw_pc !== op.pc || cw_write_sel !== op.sel || cw_is_wb !== e.wb) begin
          failures++;
          $display("FAIL %s cw_record got pc=%h sel=%0d wb=%b exp pc=%h sel=%0d wb=%b",
                   name, cw_pc, cw_write_sel, cw_is_wb, op.pc, op.sel, e.wb);
        end
        if (!e.err) begin
          checks++;
          if (cw_data !== e.data) begin
            failures++; $display("FAIL %s cw_data got=%h exp=%h", name, cw_data, e.data);
          end
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    #3;
    checks++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, cw_valid, cw_pc, cw_write_sel,
         cw_is_wb, cw_data, cw_mem_err} !== '0) begin
      failures++; $display("FAIL reset_outputs got req=%b valid=%b pc=%h data=%h exp all zero",
                           mem_req, cw_valid, cw_pc, cw_data);
    end
    checks++;
    if (c_ready !== 1'b1) begin
      failures++; $display("FAIL reset_c_ready got=%b exp=1", c_ready);
    end
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
  endtask

  task automatic test_back_to_back();
    run_op("b2b_0", mk_op(32'h1000, 5'd5, 0, 0, 1, 32'h11, 32'h0), 0, '0, 1'b0);
    run_op("b2b_1", mk_op(32'h1004, 5'd5, 0, 0, 1, 32'h22, 32'h0), 0, '0, 1'b1);
    run_op("b2b_2", mk_op(32'h1008, 5'd5, 0, 0, 1, 32'h33, 32'h0), 0, '0, 1'b0);
  endtask

  task automatic test_load();
    run_op("load_ack3", mk_op(32'h2000, 5'd7, 1, 0, 1, 32'h100, 32'h5555), 3, 32'hDEADBEEF, 1'b1);
  endtask

  task automatic test_store();
    run_op("store_ack1", mk_op(32'h2004, 5'd9, 0, 1, 0, 32'h200, 32'hCAFE0001), 1, 32'h12345678, 1'b0);
    run_op("load_store_both", mk_op(32'h2008, 5'd3, 1, 1, 1, 32'h204, 32'hABCD0000), 2, 32'h87654321, 1'b0);
  endtask

  task automatic test_misaligned();
    run_op("misaligned_load", mk_op(32'h3000, 5'd4, 1, 0, 1, 32'h102, 32'h0), 1, 32'h1, 1'b0);
    run_op("write_x0", mk_op(32'h3004, 5'd0, 0, 0, 1, 32'h77, 32'h0), 0, '0, 1'b0);
  endtask

  task automatic test_timeout();
    run_op("timeout_noack", mk_op(32'h4000, 5'd6, 1, 0, 1, 32'h300, 32'h0), TO + 1, 32'h0, 1'b0);
    run_op("timeout_ack_last", mk_op(32'h4004, 5'd6, 1, 0, 1, 32'h304, 32'h0), TO, 32'hFEEDF00D, 1'b0);
  endtask

  task automatic test_reset_mid_access();
    a_ready = 1'b1; ac_pc = 32'h5000; ac_write_sel = 5'd8; ac_is_load = 1'b1;
    ALU_result = 32'h400; ac_is_wb = 1'b1;
    @(posedge clock); #1 idle_inputs();           // cycle N+1
    @(posedge clock); #1;                         // cycle N+2
    checks++;
    if (mem_req !== 1'b1) begin
      failures++; $display("FAIL rst_mid req_before got=%b exp=1", mem_req);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || c_ready !== 1'b1 || cw_valid !== 1'b0) begin
      failures++; $display("FAIL rst_mid during got req=%b rdy=%b valid=%b exp req=0 rdy=1 valid=0",
                           mem_req, c_ready, cw_valid);
    end
    @(posedge clock); #1 reset = 1'b1;
    for (int k = 0; k < TO + 2; k++) begin
      @(posedge clock); #1;
      mem_ack = 1'($urandom);  // stray acks with no request outstanding
      #1;
      checks++;
      if (cw_valid !== 1'b0 || cw_mem_err !== 1'b0 || mem_req !== 1'b0 || c_ready !== 1'b1) begin
        failures++; $display("FAIL rst_mid after%0d got valid=%b err=%b req=%b rdy=%b exp 0 0 0 1",
                             k, cw_valid, cw_mem_err, mem_req, c_ready);
      end
    end
    idle_inputs();
    @(posedge clock); #1;
    run_op("post_reset_alu", mk_op(32'h5004, 5'd2, 0, 0, 1, 32'h99, 32'h0), 0, '0, 1'b0);
    run_op("post_reset_load", mk_op(32'h5008, 5'd2, 1, 0, 1, 32'h404, 32'h0), 2, 32'h0BADC0DE, 1'b0);
  endtask

  task automatic test_random();
    op_t op;
    for (int i = 0; i < 60; i++) begin
      op.pc       = $urandom;
      op.sel      = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      op.is_load  = 1'($urandom);
      op.is_store = 1'($urandom);
      op.is_wb    = 1'($urandom);
      op.result   = $urandom;
      if ($urandom_range(0, 3) != 0) op.result[1:0] = 2'b00;
      op.sdata    = $urandom;
      run_op($sformatf("rand%0d", i), op, $urandom_range(1, TO + 1), $urandom, 1'($urandom));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_load();
    test_store();
    test_misaligned();
    test_timeout();
    test_reset_mid_access();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
